// File: rtl/demux_1to4_collect.sv
// Registered 1:4 demux: steers one W-bit beat per cycle into one of four lanes
// and pulses Y_valid when a full 4-lane frame has been collected.
module demux_1to4_collect #(
  parameter int W        = 1,
  parameter bit AUTO_SEL = 1'b1
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic [W-1:0]   D,
  input  logic           D_valid,
  input  logic [1:0]     Sel,
  input  logic           Sync,
  output logic [4*W-1:0] Y,
  output logic [3:0]     Y_en,
  output logic           Y_valid,
  output logic [1:0]     Slot
);

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    case (idx)
      2'd0:    onehot4 = 4'b0001;
      2'd1:    onehot4 = 4'b0010;
      2'd2:    onehot4 = 4'b0100;
      2'd3:    onehot4 = 4'b1000;
      default: onehot4 = 4'b0000;
    endcase
  endfunction

  logic [4*W-1:0] y_q, y_d;
  logic [3:0]     y_en_q, y_en_d;
  logic           y_valid_q, y_valid_d;
  logic [1:0]     slot_q, slot_d;
  logic [3:0]     mask_q, mask_d;

  logic [1:0]     slot_base_s;
  logic [3:0]     mask_base_s;
  logic [3:0]     mask_acc_s;
  logic [1:0]     lane_s;

  // Next-state: Sync restarts the frame before the current beat is placed.
  always_comb begin
    slot_base_s = Sync ? 2'd0 : slot_q;
    mask_base_s = Sync ? 4'b0000 : mask_q;
    lane_s      = AUTO_SEL ? slot_base_s : Sel;
    mask_acc_s  = mask_base_s | onehot4(lane_s);
    y_d         = y_q;
    y_en_d      = 4'b0000;
    y_valid_d   = 1'b0;
    slot_d      = AUTO_SEL ? slot_base_s : 2'd0;
    mask_d      = AUTO_SEL ? 4'b0000 : mask_base_s;
    if (D_valid) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_s == 2'(k)) begin
          y_d[k*W +: W] = D;
        end else begin
          y_d[k*W +: W] = y_q[k*W +: W];
        end
      end
      y_en_d = onehot4(lane_s);
      if (AUTO_SEL) begin
        slot_d    = slot_base_s + 2'd1;
        y_valid_d = (lane_s == 2'd3);
      end else if (mask_acc_s == 4'b1111) begin
        y_valid_d = 1'b1;
        mask_d    = 4'b0000;
      end else begin
        mask_d    = mask_acc_s;
      end
    end else begin
      y_en_d    = 4'b0000;
      y_valid_d = 1'b0;
    end
  end

  // State registers with immediate asynchronous clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      y_q       <= '0;
      y_en_q    <= 4'b0000;
      y_valid_q <= 1'b0;
      slot_q    <= 2'd0;
      mask_q    <= 4'b0000;
    end else begin
      y_q       <= y_d;
      y_en_q    <= y_en_d;
      y_valid_q <= y_valid_d;
      slot_q    <= slot_d;
      mask_q    <= mask_d;
    end
  end

  assign Y       = y_q;
  assign Y_en    = y_en_q;
  assign Y_valid = y_valid_q;
  assign Slot    = slot_q;

endmodule
